// File: rtl/npu_mac_pkg.sv
// npu_mac_pkg: shared default widths, saturation limits and the narrowing helper for the MAC array
package npu_mac_pkg;
  localparam int DEF_LANES  = 4;
  localparam int DEF_DATA_W = 8;
  localparam int DEF_ACC_W  = 16;
  localparam int DEF_OUT_W  = 8;
  localparam logic signed [DEF_ACC_W-1:0] ACC_MAX = {1'b0, {(DEF_ACC_W-1){1'b1}}};
  localparam logic signed [DEF_ACC_W-1:0] ACC_MIN = {1'b1, {(DEF_ACC_W-1){1'b0}}};
  localparam logic signed [DEF_OUT_W-1:0] OUT_MAX = {1'b0, {(DEF_OUT_W-1){1'b1}}};
  localparam logic signed [DEF_OUT_W-1:0] OUT_MIN = {1'b1, {(DEF_OUT_W-1){1'b0}}};
  // Clamps a sign-extended value into the n-bit signed range; caller truncates to n bits.
  function automatic logic signed [63:0] sat_trunc(input logic signed [63:0] x, input int n);
    logic signed [63:0] hi;
    hi = (64'sd1 <<< (n - 1)) - 64'sd1;
    return x > hi ? hi : (x < -hi - 64'sd1 ? -hi - 64'sd1 : x);
  endfunction
endpackage

// File: rtl/mac_lane.sv
// mac_lane: one signed MAC lane: product register, saturating accumulate, rounding requantiser
module mac_lane
  import npu_mac_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ACC_W  = DEF_ACC_W,
  parameter int OUT_W  = DEF_OUT_W,
  parameter int SW     = $clog2(DEF_ACC_W)
) (
  input  logic                     CLKEXT,
  input  logic                     RST,
  input  logic                     EN_MAC,
  input  logic signed [DATA_W-1:0] a,
  input  logic signed [DATA_W-1:0] b,
  input  logic signed [ACC_W-1:0]  bias,
  input  logic                     v1,
  input  logic                     bias_ld1,
  input  logic                     yv2,
  input  logic [SW-1:0]            shift2,
  input  logic                     relu2,
  output logic signed [ACC_W-1:0]  acc,
  output logic signed [OUT_W-1:0]  y,
  output logic                     sat
);
  logic signed [2*DATA_W-1:0] p1;
  logic signed [ACC_W-1:0]    bias1, base, acc_n;
  logic signed [ACC_W:0]      sum, rnd, r, rq;
  logic signed [OUT_W-1:0]    y_n;
  logic                       sat_n;
  always_comb begin
    base  = bias_ld1 ? bias1 : acc;
    sum   = (ACC_W+1)'(base) + (ACC_W+1)'(p1);
    sat_n = sum[ACC_W] ^ sum[ACC_W-1];
    acc_n = ACC_W'(sat_trunc(64'(sum), ACC_W));
    rnd   = shift2 == '0 ? '0 : (ACC_W+1)'(1) << (shift2 - SW'(1));
    r     = ((ACC_W+1)'(acc) + rnd) >>> shift2;
    rq    = relu2 && r[ACC_W] ? '0 : r;
    y_n   = OUT_W'(sat_trunc(64'(rq), OUT_W));
  end
  always_ff @(posedge CLKEXT) begin
    if (RST) begin
      p1    <= '0;
      bias1 <= '0;
      acc   <= '0;
      sat   <= 1'b0;
      y     <= '0;
    end else begin
      if (EN_MAC) begin
        p1    <= (2*DATA_W)'(a) * (2*DATA_W)'(b);
        bias1 <= bias;
      end
      if (v1) begin
        acc <= acc_n;
        sat <= sat_n | (sat & ~bias_ld1);
      end
      if (yv2) y <= y_n;
    end
  end
endmodule

// File: rtl/mac_array_pipe.sv
// mac_array_pipe: LANES-wide pipelined MAC array with shared control pipeline and requantised output
module mac_array_pipe
  import npu_mac_pkg::*;
#(
  parameter int LANES  = DEF_LANES,
  parameter int DATA_W = DEF_DATA_W,
  parameter int ACC_W  = DEF_ACC_W,
  parameter int OUT_W  = DEF_OUT_W
) (
  input  logic                       CLKEXT,
  input  logic                       RST,
  input  logic                       EN_MAC,
  input  logic                       BIAS_LD,
  input  logic                       LAST,
  input  logic [LANES*DATA_W-1:0]    A,
  input  logic [LANES*DATA_W-1:0]    B,
  input  logic [LANES*ACC_W-1:0]     BIAS_IN,
  input  logic [$clog2(ACC_W)-1:0]   SHIFT,
  input  logic                       RELU_EN,
  output logic [LANES*ACC_W-1:0]     ACC,
  output logic [LANES*OUT_W-1:0]     Y,
  output logic                       Y_VALID,
  output logic [LANES-1:0]           SAT_FLAG
);
  localparam int SW = $clog2(ACC_W);
  logic          v1, bias_ld1, last1, relu1, yv2, relu2;
  logic [SW-1:0] shift1, shift2;
  // S3 control rides one stage behind S2 so requantisation sees the freshly written ACC.
  always_ff @(posedge CLKEXT) begin
    if (RST) begin
      v1       <= 1'b0;
      bias_ld1 <= 1'b0;
      last1    <= 1'b0;
      shift1   <= '0;
      relu1    <= 1'b0;
      yv2      <= 1'b0;
      shift2   <= '0;
      relu2    <= 1'b0;
      Y_VALID  <= 1'b0;
    end else begin
      v1 <= EN_MAC;
      if (EN_MAC) begin
        bias_ld1 <= BIAS_LD;
        last1    <= LAST;
        shift1   <= SHIFT;
        relu1    <= RELU_EN;
      end
      yv2     <= v1 & last1;
      shift2  <= shift1;
      relu2   <= relu1;
      Y_VALID <= yv2;
    end
  end
  for (genvar i = 0; i < LANES; i++) begin : g_lane
    mac_lane #(.DATA_W(DATA_W), .ACC_W(ACC_W), .OUT_W(OUT_W), .SW(SW)) u_lane (
      .CLKEXT  (CLKEXT),
      .RST     (RST),
      .EN_MAC  (EN_MAC),
      .a       (A[i*DATA_W +: DATA_W]),
      .b       (B[i*DATA_W +: DATA_W]),
      .bias    (BIAS_IN[i*ACC_W +: ACC_W]),
      .v1      (v1),
      .bias_ld1(bias_ld1),
      .yv2     (yv2),
      .shift2  (shift2),
      .relu2   (relu2),
      .acc     (ACC[i*ACC_W +: ACC_W]),
      .y       (Y[i*OUT_W +: OUT_W]),
      .sat     (SAT_FLAG[i])
    );
  end
endmodule

// File: tb/tb_mac_array_pipe.sv
// tb_mac_array_pipe: randomized scoreboard bench with a plain-arithmetic dot-product model
module tb_mac_array_pipe;
  localparam int L = 4;
  logic        CLKEXT = 1'b0, RST = 1'b1, EN_MAC = 1'b0, BIAS_LD = 1'b0, LAST = 1'b0, RELU_EN = 1'b0;
  logic [31:0] A = '0, B = '0;
  logic [63:0] BIAS_IN = '0;
  logic [3:0]  SHIFT = '0;
  logic [63:0] ACC;
  logic [31:0] Y;
  logic        Y_VALID;
  logic [3:0]  SAT_FLAG;

  mac_array_pipe dut (
    .CLKEXT(CLKEXT), .RST(RST), .EN_MAC(EN_MAC), .BIAS_LD(BIAS_LD), .LAST(LAST),
    .A(A), .B(B), .BIAS_IN(BIAS_IN), .SHIFT(SHIFT), .RELU_EN(RELU_EN),
    .ACC(ACC), .Y(Y), .Y_VALID(Y_VALID), .SAT_FLAG(SAT_FLAG)
  );

  always #5 CLKEXT = ~CLKEXT;

  int cyc = 0;
  always @(posedge CLKEXT) cyc <= cyc + 1;

  typedef struct {int c; logic [63:0] acc; logic [3:0] sat;} acc_t;
  typedef struct {int c; logic [31:0] y;} y_t;
  acc_t aq[$];
  y_t   yq[$];
  int   vectors = 0, miscompares = 0;
  int   m_acc[L];
  bit   m_sat[L];

  function automatic int clamp(int x, int n);
    int hi;
    hi = (1 << (n - 1)) - 1;
    return x > hi ? hi : (x < -hi - 1 ? -hi - 1 : x);
  endfunction

  function automatic int rs8();
    return int'($urandom_range(255)) - 128;
  endfunction

  function automatic int rs16();
    return int'($urandom_range(65535)) - 32768;
  endfunction

  function automatic acc_t snap(int c);
    acc_t s;
    s.c = c;
    for (int i = 0; i < L; i++) begin
      s.acc[i*16 +: 16] = m_acc[i][15:0];
      s.sat[i] = m_sat[i];
    end
    return s;
  endfunction

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  // Issues one term (or a bubble with garbage inputs) on the next negedge and updates the model.
  task automatic term(bit en, bit bld, bit last, int a0, int b0, int bias0, int sh, bit relu);
    int a, b, bs, s, c, r;
    logic [31:0] yv;
    @(negedge CLKEXT);
    EN_MAC = en;
    SHIFT = sh[3:0];
    RELU_EN = relu;
    yv = '0;
    if (!en) begin
      BIAS_LD = 1'($urandom);
      LAST = 1'($urandom);
      A = $urandom;
      B = $urandom;
      BIAS_IN = {$urandom, $urandom};
    end else begin
      BIAS_LD = bld;
      LAST = last;
      for (int i = 0; i < L; i++) begin
        a  = i == 0 ? a0 : rs8();
        b  = i == 0 ? b0 : rs8();
        bs = i == 0 ? bias0 : rs16();
        A[i*8 +: 8] = a[7:0];
        B[i*8 +: 8] = b[7:0];
        BIAS_IN[i*16 +: 16] = bs[15:0];
        s = (bld ? bs : m_acc[i]) + a * b;
        c = clamp(s, 16);
        m_sat[i] = (c != s) || (!bld && m_sat[i]);
        m_acc[i] = c;
        if (last) begin
          r = (m_acc[i] + (sh > 0 ? (1 << (sh - 1)) : 0)) >>> sh;
          if (relu && r < 0) r = 0;
          r = clamp(r, 8);
          yv[i*8 +: 8] = r[7:0];
        end
      end
      if (last) yq.push_back('{cyc + 3, yv});
    end
    aq.push_back(snap(cyc + 2));
  endtask

  task automatic bubble();
    term(1'b0, 1'b0, 1'b0, 0, 0, 0, 0, 1'b0);
  endtask

  task automatic chk_y0(string name, int exp);
    for (int k = 0; k < 6; k++) begin
      bubble();
      if (Y_VALID) begin
        check(name, 64'(Y[7:0]), 64'(exp[7:0]));
        return;
      end
    end
    check({name, "_timeout"}, 64'(Y_VALID), 64'd1);
  endtask

  // Anything scheduled beyond the reset edge is discarded by the DUT, so drop it here too.
  task automatic do_reset();
    @(negedge CLKEXT);
    RST = 1'b1;
    EN_MAC = 1'b0;
    aq = aq.find with (item.c <= cyc);
    yq = yq.find with (item.c <= cyc);
    for (int i = 0; i < L; i++) begin
      m_acc[i] = 0;
      m_sat[i] = 1'b0;
    end
    aq.push_back(snap(cyc + 1));
    @(negedge CLKEXT);
    check("rst_y", 64'(Y), 64'd0);
    check("rst_y_valid", 64'(Y_VALID), 64'd0);
    RST = 1'b0;
  endtask

  always @(negedge CLKEXT) begin
    if (aq.size() != 0 && aq[0].c == cyc) begin
      check("acc", ACC, aq[0].acc);
      check("sat_flag", 64'(SAT_FLAG), 64'(aq[0].sat));
      void'(aq.pop_front());
    end
    if (Y_VALID) begin
      if (yq.size() != 0 && yq[0].c == cyc) begin
        check("y", 64'(Y), 64'(yq[0].y));
        void'(yq.pop_front());
      end else check("y_valid_unexpected", 64'(Y_VALID), 64'd0);
    end else if (yq.size() != 0 && yq[0].c <= cyc) begin
      check("y_valid_missing", 64'(Y_VALID), 64'd1);
      void'(yq.pop_front());
    end
  end

  initial begin
    for (int i = 0; i < L; i++) begin
      m_acc[i] = 0;
      m_sat[i] = 1'b0;
    end
    do_reset();
    term(1, 1, 0, 3, 4, 100, 0, 0);
    term(1, 0, 1, -2, 5, rs16(), 0, 0);
    chk_y0("bias_acc_y", 102);
    term(1, 1, 0, 127, 127, 32000, 0, 0);
    term(1, 0, 1, -128, 1, 0, 0, 0);
    chk_y0("pos_sat_y", 127);
    term(1, 1, 1, 1, 1, 0, 0, 0);
    chk_y0("flag_clear_y", 1);
    term(1, 1, 1, -128, 127, -32768, 0, 0);
    chk_y0("neg_sat_y", -128);
    term(1, 1, 1, 0, 0, 1000, 3, 0);
    chk_y0("rq_shift3_y", 125);
    term(1, 1, 1, 0, 0, 1000, 2, 0);
    chk_y0("rq_shift2_sat_y", 127);
    term(1, 1, 1, 0, 0, -300, 0, 1);
    chk_y0("rq_relu_y", 0);
    term(1, 1, 1, 0, 0, -300, 2, 0);
    chk_y0("rq_neg_y", -75);
    for (int k = 0; k < 4; k++) begin
      term(1, k == 0, k == 3, rs8(), rs8(), rs16(), int'($urandom_range(15)), 1'($urandom));
      bubble();
    end
    term(1, 1, 1, rs8(), rs8(), rs16(), int'($urandom_range(15)), 1'($urandom));
    repeat (4) bubble();
    repeat (400)
      term($urandom_range(3) != 0, $urandom_range(4) == 0, $urandom_range(4) == 0,
           rs8(), rs8(), rs16(), int'($urandom_range(15)), 1'($urandom));
    repeat (4) bubble();
    term(1, 1, 0, rs8(), rs8(), rs16(), 0, 0);
    term(1, 0, 1, rs8(), rs8(), rs16(), 0, 0);
    do_reset();
    repeat (3) bubble();
    term(1, 1, 1, 5, 6, 7, 0, 0);
    chk_y0("post_rst_y", 37);
    repeat (6) bubble();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/mac_array_pipe.md
# mac_array_pipe

Parametrised, pipelined multi-lane multiply-accumulate unit for the NPU datapath. It is the successor to the single 8-bit MAC and feeds a row of processing elements. Each lane computes a signed dot-product with saturating accumulation and optional bias preload. A final term flagged `LAST` triggers a requantised output with rounding shift, optional ReLU, and saturation to the output width, qualified by a one-cycle valid pulse. All lanes share control; there is no back-pressure.

## Interface
Parameters:
- `LANES`, 4, number of independent MAC lanes.
- `DATA_W`, 8, signed operand width. Constraint: 2·`DATA_W` ≤ `ACC_W`.
- `ACC_W`, 16, signed accumulator and bias width.
- `OUT_W`, 8, signed requantised output width. Constraint: `OUT_W` ≤ `ACC_W`.

Ports:
- `CLKEXT`  in  1  clock; all logic on its rising edge.
- `RST`  in  1  synchronous, active-high reset.
- `EN_MAC`  in  1  input term valid; all other inputs are ignored when low.
- `BIAS_LD`  in  1  with `EN_MAC`: start a new dot-product from `BIAS_IN`.
- `LAST`  in  1  with `EN_MAC`: this term closes the dot-product.
- `A`, `B`  in  `LANES`·`DATA_W`  packed signed operands; lane i occupies bits [i·`DATA_W` +: `DATA_W`].
- `BIAS_IN`  in  `LANES`·`ACC_W`  packed signed per-lane bias.
- `SHIFT`  in  `$clog2(ACC_W)`  requantisation right-shift; sampled with `LAST`.
- `RELU_EN`  in  1  clamp negative results to 0; sampled with `LAST`.
- `ACC`  out  `LANES`·`ACC_W`  registered accumulators.
- `Y`  out  `LANES`·`OUT_W`  registered requantised results.
- `Y_VALID`  out  1  one-cycle pulse; `Y` is valid while it is high.
- `SAT_FLAG`  out  `LANES`  sticky flag per lane: saturation occurred in the current dot-product.

## Operation
- **Stage 1 (S1):** when `EN_MAC` is high, register per-lane `P` = `A`·`B` (signed, 2·`DATA_W` bits). Also register `BIAS_LD`, `LAST`, `SHIFT`, `RELU_EN`, the bias values, and a valid bit `v1`.
- **Stage 2 (S2):** when `v1` is high, compute base = `BIAS_IN` (registered) if `BIAS_LD` was set, else `ACC`.
  - `sum` = sign-extend(base, `ACC_W`+1) + sign-extend(`P`, `ACC_W`+1).
  - Saturate `sum` to `ACC_W`: top two bits 01 → +max, 10 → −min, otherwise `sum[ACC_W-1:0]`.
  - Write the result to `ACC`.
- **`SAT_FLAG[i]`:** set when lane i saturates in S2. On a `BIAS_LD` term it is written to that term's saturation result rather than OR-ed with the old flag.
- **Stage 3 (S3):** when S2 processed a `LAST` term, take the new `ACC` value `a`.
  - Rounding: `r` = (`a` + (`SHIFT`>0 ? 1<<(`SHIFT`−1) : 0)) >>> `SHIFT`, computed in `ACC_W`+1 bits.
  - If `RELU_EN` is set and `r` < 0, then `r` = 0.
  - Saturate `r` to `OUT_W` and register it into `Y`.
  - Assert `Y_VALID` for exactly one cycle.
- **`BIAS_LD` and `LAST` on the same term:** a single-term dot-product; legal.
- **`EN_MAC` low:** a bubble. `ACC` holds, `SAT_FLAG` holds, and no `Y_VALID`. Bubbles may appear anywhere, including between `BIAS_LD` and `LAST`.
- **Back-to-back dot-products:** `LAST` on term k followed by `BIAS_LD` on term k+1 is supported at full rate with no dead cycle.
- **Term without `BIAS_LD` after `LAST`:** keeps accumulating onto the previous value. This is legal and not flagged.
- **`Y`:** holds its last value between pulses.

## Timing
- Every register resets to 0 on the first edge with `RST` high: `ACC`, `Y`, `Y_VALID`, `SAT_FLAG`, and pipeline valids.
- Latency, for a term sampled on edge n:
  - `P` is registered at n.
  - `ACC` and `SAT_FLAG` update at n+1.
  - `Y` and `Y_VALID` update at n+2.
- Throughput is one term per cycle per lane. There is no stall or ready signal.
- `RST` mid-operation discards all in-flight S1/S2 terms. No `Y_VALID` is produced for them, including when `RST` and an in-flight `LAST` coincide.
- `RST` has priority over `EN_MAC` on the same edge.

## Structure
- Shared package `npu_mac_pkg` holds:
  - default `DATA_W`, `ACC_W`, `OUT_W`, `LANES`;
  - saturation-limit constants;
  - a `sat_trunc` function that narrows an (N+1)-bit signed value to N bits.
- Sub-module `mac_lane`: one lane with stages S1–S3, parametrised by the widths.
- `mac_array_pipe` contains:
  - a generate loop of `LANES` `mac_lane` instances;
  - the shared control pipeline: `v1`, `BIAS_LD`, `LAST`, `SHIFT`, `RELU_EN`, and the S2→S3 valid bit that drives `Y_VALID`.

## Test plan
All scenarios use the default parameters.
- **Bias load and accumulate:** lane 0 gets `BIAS`=100, `A`=3, `B`=4 with `BIAS_LD`, then `A`=−2, `B`=5 with `LAST`, `SHIFT`=0. Expect `ACC`=112 then 102, `Y`=102, with `Y_VALID` two cycles after the `LAST` edge.
- **Positive saturation:** `BIAS`=32000, `A`=127, `B`=127 with `BIAS_LD`. Expect `ACC`=32767 and `SAT_FLAG[0]`=1. Then `A`=−128, `B`=1 with `LAST`: expect `ACC`=32639, `Y`=127, and the flag stays 1. A following `BIAS_LD` term without overflow writes the flag to 0.
- **Negative saturation:** `BIAS`=−32768, `A`=−128, `B`=127, with `BIAS_LD` and `LAST`. Expect `ACC`=−32768, `SAT_FLAG`=1, `Y`=−128.
- **Requantisation:**
  - final `ACC`=1000, `SHIFT`=3 → `Y`=125;
  - final `ACC`=1000, `SHIFT`=2 → `Y`=127 (saturated);
  - final `ACC`=−300, `RELU_EN`=1 → `Y`=0;
  - final `ACC`=−300, `RELU_EN`=0, `SHIFT`=2 → `Y`=−75.
- **Bubbles and back-to-back:** a 4-term dot-product with `EN_MAC` low between every term, immediately followed by a `BIAS_LD` term. Expect the correct sum, exactly one `Y_VALID`, the second sum independent of the first, and distinct per-lane values across all 4 lanes.
- **Reset mid-stream:** assert `RST` on the edge after a `LAST` term is sampled. Expect every output to be 0 next cycle, `Y_VALID` never to assert, and a subsequent `BIAS_LD` dot-product to behave normally.
